// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants and branch-resolve state encoding.
// Revision: 1.0
`default_nettype none

package cpu_pkg;

  localparam int ADDR_W = 10;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    CORRECT = 2'd1,
    DRAIN   = 2'd2
  } bru_state_t;

endpackage

`default_nettype wire

// File: rtl/br_fifo.sv
// br_fifo: in-order branch-record FIFO with synchronous clear.
// Revision: 1.0
`default_nettype none

module br_fifo #(
  parameter int AW    = 10,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [AW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/branch_resolve.sv
// branch_resolve: tracks predicted-not-taken branches and redirects fetch on mispredict.
// Optional BRANCH_RESOLVE_STATS_EN adds saturating resolve/mispredict counters. Revision: 1.0
`default_nettype none

module branch_resolve
  import cpu_pkg::*;
#(
  parameter int AW           = ADDR_W,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq_valid,
  input  logic [AW-1:0] enq_target,
  input  logic          resolve_valid,
  input  logic          resolve_taken,
  output logic          correct_en,
  output logic [AW-1:0] correction,
  output logic          flush,
  output logic          hold,
  output logic          err
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [15:0]   stat_resolved,
  output logic [15:0]   stat_mispred
`endif
);

  bru_state_t    state;
  logic [2:0]    drain_cnt;
  logic          full;
  logic          empty;
  logic [AW-1:0] head;
  logic          in_run;
  logic          enq_ok;
  logic          res_ok;
  logic          mispredict;
  logic          err_next;

  assign in_run     = (state == RUN);
  assign enq_ok     = in_run && enq_valid && !full;
  assign res_ok     = in_run && resolve_valid && !empty;
  assign mispredict = res_ok && resolve_taken;
  // Enq outside RUN is silently dropped; resolve outside RUN is a violation.
  assign err_next   = (in_run && enq_valid && full) ||
                      (resolve_valid && (!in_run || empty));
  assign hold       = full || !in_run;

  br_fifo #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (enq_ok && !mispredict),
    .pop   (res_ok && !resolve_taken),
    .clear (mispredict),
    .din   (enq_target),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      drain_cnt  <= '0;
      correct_en <= 1'b0;
      correction <= '0;
      flush      <= 1'b0;
      err        <= 1'b0;
    end else begin
      err        <= err_next;
      correct_en <= 1'b0;
      case (state)
        RUN: begin
          if (mispredict) begin
            correct_en <= 1'b1;
            correction <= head;
            flush      <= 1'b1;
            state      <= CORRECT;
          end
        end
        CORRECT: begin
          drain_cnt <= 3'(FLUSH_CYCLES - 1);
          state     <= DRAIN;
        end
        DRAIN: begin
          if (drain_cnt == 3'd0) begin
            flush <= 1'b0;
            state <= RUN;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (res_ok && stat_resolved != 16'hFFFF) stat_resolved <= stat_resolved + 16'd1;
      if (mispredict && stat_mispred != 16'hFFFF) stat_mispred <= stat_mispred + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
- REQ-001 SHALL have parameter AW, default 10: instruction address width.
- REQ-002 SHALL have parameter DEPTH, default 4: in-flight branch records; power of two, at least 2.
- REQ-003 SHALL have parameter FLUSH_CYCLES, default 2: wrong-path suppression cycles after a correction; range 1..7.
- REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
- REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
- REQ-006 SHALL have port enq_valid, input, 1: fetch predicted a conditional branch not-taken this cycle.
- REQ-007 SHALL have port enq_target, input, AW: taken target of that branch.
- REQ-008 SHALL have port resolve_valid, input, 1: execute resolved the oldest in-flight branch.
- REQ-009 SHALL have port resolve_taken, input, 1: that branch was taken.
- REQ-010 SHALL have port correct_en, output, 1: redirect strobe to fetch.
- REQ-011 SHALL have port correction, output, AW: redirect PC.
- REQ-012 SHALL have port flush, output, 1: kill younger in-flight instructions.
- REQ-013 SHALL have port hold, output, 1: stall fetch.
- REQ-014 SHALL have port err, output, 1: one-cycle protocol-violation pulse.

Function
- REQ-015 SHALL keep branch records in order in a DEPTH-entry FIFO; push on accepted enq, pop on resolve_valid.
- REQ-016 SHALL drive hold high while FIFO count equals DEPTH or state is not RUN.
- REQ-017 SHALL ignore enq_valid while full and pulse err the next cycle; an enq while full with a same-cycle resolve is still rejected.
- REQ-018 SHALL ignore resolve_valid while empty and pulse err the next cycle.
- REQ-019 SHALL, in RUN with simultaneous accepted enq and resolve, push and pop together, leaving count unchanged.
- REQ-020 SHALL treat resolve_taken=0 as a correct prediction: pop only, no outputs.
- REQ-021 SHALL treat resolve_taken=1 as a mispredict: next cycle correct_en=1, flush=1, correction=head target, all FIFO entries discarded, state RUN->CORRECT.
- REQ-022 SHALL assert correct_en for exactly one cycle per mispredict; correction holds its value until the next mispredict.
- REQ-023 SHALL use states RUN, CORRECT and DRAIN.
- REQ-024 SHALL transition CORRECT->DRAIN unconditionally after one cycle, loading the drain counter with FLUSH_CYCLES-1.
- REQ-025 SHALL, in DRAIN, ignore enq_valid without err, decrement the counter each cycle, and enter RUN after the cycle in which the counter is 0.
- REQ-026 SHALL, in CORRECT and DRAIN, ignore resolve_valid and pulse err.
- REQ-027 SHALL hold flush high from the correct_en cycle through the last DRAIN cycle, i.e. FLUSH_CYCLES+1 cycles in total.
- REQ-028 SHALL compute FIFO pointers modulo DEPTH, wrapping without gaps.
- REQ-029 SHALL register all outputs except hold; hold is combinational from count and state.

Reset
- REQ-030 SHALL, on rst=1 at a clock edge, clear the FIFO, set state RUN, and force correct_en=0, correction=0, flush=0, err=0, hold=0 and the counters to 0.
- REQ-031 SHALL let rst override any simultaneous enq, resolve or mid-drain activity; no correction is emitted.

Configuration
- REQ-032 SHALL, with BRANCH_RESOLVE_STATS_EN defined, add outputs stat_resolved[15:0] and stat_mispred[15:0], which saturate at 16'hFFFF, count accepted resolves and mispredicts, and are cleared by rst.
- REQ-033 SHALL, without BRANCH_RESOLVE_STATS_EN, omit those ports and their logic; all other behaviour is identical.

Structure
- REQ-034 SHALL import a shared package cpu_pkg that holds the address-width constant and the bru_state_t enum (RUN, CORRECT, DRAIN).
- REQ-035 SHALL instantiate one sub-module br_fifo (parameterised AW and DEPTH, with push, pop, clear, full, empty and head).

Verification
- REQ-036 SHALL cover: enq target 0x040, then resolve_taken=0 -> no correct_en, FIFO empty, err=0.
- REQ-037 SHALL cover: enq 0x040 and 0x080, resolve_taken=1 -> next cycle correct_en=1, correction=0x040, flush high 3 cycles, FIFO empty, hold low after DRAIN.
- REQ-038 SHALL cover: 4 enqs -> hold=1; 5th enq -> err pulse; 5th enq plus resolve in the same cycle -> count becomes 3.
- REQ-039 SHALL cover: resolve while empty -> err=1 for one cycle, state stays RUN.
- REQ-040 SHALL cover: rst asserted during DRAIN -> next cycle flush=0, hold=0, state RUN, and an enq is accepted immediately.
- REQ-041 SHALL cover: 6 push/pop pairs at DEPTH=4 -> pointer wrap, with heads popped in enq order.
